// File: rtl/hoop_scene_ctrl.sv
// Frame-synchronous hoop controller: bouncing rim position, score-flash recolouring
// and a two-digit BCD score. All outputs are registered so the renderer never sees mid-frame changes.
module hoop_scene_ctrl #(
    parameter int unsigned Y_MIN        = 100,
    parameter int unsigned Y_MAX        = 400,
    parameter int unsigned Y_RESET      = 254,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned FLASH_COUNT  = 3,
    parameter logic [11:0] COLOR_NORMAL = 12'hF00,
    parameter logic [11:0] COLOR_FLASH  = 12'h0F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        score_event,
    input  logic [1:0]  level_sel,
    output logic [9:0]  rim_y,
    output logic [9:0]  board_y,
    output logic [11:0] rim_rgb,
    output logic        flash_on,
    output logic [7:0]  score_bcd
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_FLASH_ON  = 2'd1;
    localparam logic [1:0] S_FLASH_OFF = 2'd2;

    localparam int unsigned PW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int unsigned CW = $clog2(FLASH_COUNT + 1);

    localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_FRAMES - 1);
    localparam logic [CW-1:0] PAIRS_INIT = CW'(FLASH_COUNT);
    localparam logic [CW-1:0] PAIRS_ONE  = CW'(1);

    localparam logic [10:0] YMIN11    = 11'(Y_MIN);
    localparam logic [10:0] YMAX11    = 11'(Y_MAX);
    localparam logic [9:0]  YMIN10    = 10'(Y_MIN);
    localparam logic [9:0]  YMAX10    = 10'(Y_MAX);
    localparam logic [9:0]  YRST10    = 10'(Y_RESET);
    localparam logic [9:0]  BOARD_OFS = 10'd54;

    logic [9:0]    rim_y_q, rim_y_d;
    logic [9:0]    board_y_q, board_y_d;
    logic          dir_up_q, dir_up_d;
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] pairs_q, pairs_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          flash_q, flash_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;

    logic [10:0]   step;
    logic [10:0]   y_ext;

    always_comb begin
        case (level_sel)
            2'd0:    step = 11'd0;
            2'd1:    step = 11'd1;
            2'd2:    step = 11'd2;
            default: step = 11'd4;
        endcase
    end

    // Comparisons are done at 11 bits so y + step / Y_MIN + step never wraps.
    always_comb begin
        rim_y_d  = rim_y_q;
        dir_up_d = dir_up_q;
        y_ext    = {1'b0, rim_y_q};
        if (frame_tick && (step != '0)) begin
            if (dir_up_q) begin
                if (y_ext <= YMIN11 + step) begin
                    rim_y_d  = YMIN10;
                    dir_up_d = 1'b0;
                end else begin
                    rim_y_d = rim_y_q - step[9:0];
                end
            end else begin
                if (y_ext + step >= YMAX11) begin
                    rim_y_d  = YMAX10;
                    dir_up_d = 1'b1;
                end else begin
                    rim_y_d = rim_y_q + step[9:0];
                end
            end
        end
        board_y_d = rim_y_d - BOARD_OFS;
    end

    // A score event restarts the flash and swallows a coincident frame tick.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pairs_d = pairs_q;
        if (score_event) begin
            state_d = S_FLASH_ON;
            phase_d = '0;
            pairs_d = PAIRS_INIT;
        end else if (frame_tick) begin
            case (state_q)
                S_FLASH_ON: begin
                    if (phase_q == PHASE_LAST) begin
                        state_d = S_FLASH_OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                S_FLASH_OFF: begin
                    if (phase_q == PHASE_LAST) begin
                        pairs_d = pairs_q - 1'b1;
                        phase_d = '0;
                        state_d = (pairs_q == PAIRS_ONE) ? S_IDLE : S_FLASH_ON;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        flash_d = (state_d == S_FLASH_ON);
        rgb_d   = flash_d ? COLOR_FLASH : COLOR_NORMAL;
    end

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (score_event) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rim_y_q   <= YRST10;
            board_y_q <= YRST10 - BOARD_OFS;
            dir_up_q  <= 1'b1;
            state_q   <= S_IDLE;
            phase_q   <= '0;
            pairs_q   <= '0;
            rgb_q     <= COLOR_NORMAL;
            flash_q   <= 1'b0;
            ones_q    <= '0;
            tens_q    <= '0;
        end else begin
            rim_y_q   <= rim_y_d;
            board_y_q <= board_y_d;
            dir_up_q  <= dir_up_d;
            state_q   <= state_d;
            phase_q   <= phase_d;
            pairs_q   <= pairs_d;
            rgb_q     <= rgb_d;
            flash_q   <= flash_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
        end
    end

    assign rim_y     = rim_y_q;
    assign board_y   = board_y_q;
    assign rim_rgb   = rgb_q;
    assign flash_on  = flash_q;
    assign score_bcd = {tens_q, ones_q};

endmodule

// File: tb/tb_hoop_scene_ctrl.sv
// Scoreboard bench for hoop_scene_ctrl: the driver queues the expected outputs for every
// pulse, the monitor pops one entry per sampled pulse and otherwise checks the outputs hold.
module tb_hoop_scene_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        score_event = 1'b0;
    logic [1:0]  level_sel = 2'd0;
    logic [9:0]  rim_y;
    logic [9:0]  board_y;
    logic [11:0] rim_rgb;
    logic        flash_on;
    logic [7:0]  score_bcd;

    always #5 clk = ~clk;

    hoop_scene_ctrl #(
        .Y_MIN(100), .Y_MAX(400), .Y_RESET(254),
        .FLASH_FRAMES(8), .FLASH_COUNT(3),
        .COLOR_NORMAL(12'hF00), .COLOR_FLASH(12'h0F0)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .score_event(score_event),
        .level_sel(level_sel), .rim_y(rim_y), .board_y(board_y), .rim_rgb(rim_rgb),
        .flash_on(flash_on), .score_bcd(score_bcd)
    );

    typedef struct {
        logic [9:0]  y;
        logic [9:0]  by;
        logic [11:0] rgb;
        logic        fl;
        logic [7:0]  bcd;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural reference: flash tracked as ticks remaining out of 48.
    int m_y = 254;
    bit m_up = 1'b1;
    int m_fl_left = 0;
    int m_score = 0;

    function automatic int step_of(input logic [1:0] l);
        case (l)
            2'd0: return 0;
            2'd1: return 1;
            2'd2: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    task automatic model_step(input bit t, input bit s, input bit r);
        int st;
        if (r) begin
            m_y = 254; m_up = 1'b1; m_fl_left = 0; m_score = 0;
        end else begin
            if (t) begin
                st = step_of(level_sel);
                if (st > 0) begin
                    if (m_up) begin
                        if (m_y - st <= 100) begin m_y = 100; m_up = 1'b0; end
                        else m_y = m_y - st;
                    end else begin
                        if (m_y + st >= 400) begin m_y = 400; m_up = 1'b1; end
                        else m_y = m_y + st;
                    end
                end
            end
            if (s) begin
                m_fl_left = 48;
                m_score = (m_score + 1) % 100;
            end else if (t && m_fl_left > 0) begin
                m_fl_left = m_fl_left - 1;
            end
        end
    endtask

    task automatic pulse_core(input bit t, input bit s, input bit r, input string nm,
                              input bit hand, input logic [9:0] hy, input bit hfl,
                              input logic [7:0] hbcd);
        exp_t e;
        @(posedge clk); #1;
        frame_tick = t; score_event = s; reset = r;
        model_step(t, s, r);
        if (hand) begin
            e.y = hy; e.fl = hfl; e.bcd = hbcd;
        end else begin
            e.y   = 10'(m_y);
            e.fl  = (m_fl_left > 0) && ((((48 - m_fl_left) / 8) % 2) == 0);
            e.bcd = to_bcd(m_score);
        end
        e.by   = e.y - 10'd54;
        e.rgb  = e.fl ? 12'h0F0 : 12'hF00;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk); #1;
        frame_tick = 1'b0; score_event = 1'b0; reset = 1'b0;
    endtask

    task automatic pulse(input bit t, input bit s, input bit r, input string nm);
        pulse_core(t, s, r, nm, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic pulse_hand(input bit t, input bit s, input bit r, input string nm,
                              input logic [9:0] hy, input bit hfl, input logic [7:0] hbcd);
        pulse_core(t, s, r, nm, 1'b1, hy, hfl, hbcd);
    endtask

    logic sampled = 1'b0;
    bit   have_last = 1'b0;
    exp_t last_e;
    exp_t mon_e;

    always @(posedge clk) sampled <= reset | frame_tick | score_event;

    task automatic compare(input exp_t e);
        checks++;
        if (rim_y !== e.y || board_y !== e.by || rim_rgb !== e.rgb ||
            flash_on !== e.fl || score_bcd !== e.bcd) begin
            errors++;
            $display("FAIL %s: got y=%0d by=%0d rgb=%h fl=%b bcd=%h, expected y=%0d by=%0d rgb=%h fl=%b bcd=%h",
                     e.name, rim_y, board_y, rim_rgb, flash_on, score_bcd,
                     e.y, e.by, e.rgb, e.fl, e.bcd);
        end
    endtask

    always @(negedge clk) begin
        if (sampled) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update: no expectation queued, got y=%0d bcd=%h", rim_y, score_bcd);
            end else begin
                mon_e = sb.pop_front();
                compare(mon_e);
                last_e = mon_e;
                last_e.name = {"hold_after_", mon_e.name};
                have_last = 1'b1;
            end
        end else if (have_last) begin
            compare(last_e);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Level 1 bounce off the top limit.
        level_sel = 2'd1;
        pulse_hand(0, 0, 1, "reset_state", 10'd254, 1'b0, 8'h00);
        for (int i = 1; i <= 153; i++) pulse(1, 0, 0, "lvl1_tick");
        pulse_hand(1, 0, 0, "lvl1_clamp_top", 10'd100, 1'b0, 8'h00);
        pulse_hand(1, 0, 0, "lvl1_turn_down", 10'd101, 1'b0, 8'h00);

        // Level 3 overshoot clamp.
        level_sel = 2'd3;
        pulse_hand(0, 0, 1, "reset_lvl3", 10'd254, 1'b0, 8'h00);
        for (int i = 1; i <= 37; i++) pulse(1, 0, 0, "lvl3_tick");
        pulse_hand(1, 0, 0, "lvl3_tick38", 10'd102, 1'b0, 8'h00);
        pulse_hand(1, 0, 0, "lvl3_clamp", 10'd100, 1'b0, 8'h00);
        pulse_hand(1, 0, 0, "lvl3_down", 10'd104, 1'b0, 8'h00);

        // Static level then switch to step 2 between ticks.
        level_sel = 2'd0;
        pulse_hand(0, 0, 1, "reset_lvl0", 10'd254, 1'b0, 8'h00);
        for (int i = 1; i <= 19; i++) pulse(1, 0, 0, "lvl0_tick");
        pulse_hand(1, 0, 0, "lvl0_hold20", 10'd254, 1'b0, 8'h00);
        @(posedge clk); #1 level_sel = 2'd2;
        pulse_hand(1, 0, 0, "lvl2_first", 10'd252, 1'b0, 8'h00);

        // Full flash sequence with the rim stationary.
        level_sel = 2'd0;
        pulse_hand(0, 1, 0, "score_one", 10'd252, 1'b1, 8'h01);
        for (int i = 1; i <= 48; i++) begin
            if (i == 8)       pulse_hand(1, 0, 0, "flash_off_8", 10'd252, 1'b0, 8'h01);
            else if (i == 16) pulse_hand(1, 0, 0, "flash_on_16", 10'd252, 1'b1, 8'h01);
            else if (i == 48) pulse_hand(1, 0, 0, "flash_idle_48", 10'd252, 1'b0, 8'h01);
            else              pulse(1, 0, 0, "flash_tick");
        end
        pulse(1, 0, 0, "idle_tick");

        // Restart mid-flash with a coincident tick while moving.
        level_sel = 2'd1;
        pulse(0, 1, 0, "score_two");
        for (int i = 1; i <= 19; i++) pulse(1, 0, 0, "pre_restart_tick");
        pulse(1, 1, 0, "restart_with_tick");
        for (int i = 1; i <= 48; i++) pulse(1, 0, 0, "post_restart_tick");
        pulse(1, 0, 0, "post_restart_idle");

        // BCD wrap.
        level_sel = 2'd0;
        pulse_hand(0, 0, 1, "reset_score", 10'd254, 1'b0, 8'h00);
        for (int i = 1; i <= 98; i++) pulse(0, 1, 0, "score_inc");
        pulse_hand(0, 1, 0, "score_99", 10'd254, 1'b1, 8'h99);
        pulse_hand(0, 1, 0, "score_wrap", 10'd254, 1'b1, 8'h00);

        // Reset mid FLASH_OFF while moving, and reset overriding a tick.
        level_sel = 2'd2;
        pulse(0, 1, 0, "score_pre_reset");
        for (int i = 1; i <= 10; i++) pulse(1, 0, 0, "off_tick");
        pulse_hand(0, 0, 1, "reset_in_off", 10'd254, 1'b0, 8'h00);
        pulse(1, 1, 0, "tick_score");
        pulse(1, 0, 0, "tick_more");
        pulse_hand(1, 1, 1, "reset_overrides", 10'd254, 1'b0, 8'h00);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
